mix_columns_serial: RTL and testbench

Registered, handshaked forward AES MixColumns engine. It accepts a 128-bit state and multiplies each column by the fixed GF(2^8) matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02]. It processes COLS_PER_CYCLE columns per clock and holds the result until the consumer takes it. It sits in the encryption round datapath between ShiftRows and AddRoundKey, and is the encrypt-side counterpart of the combinational InvMixColumns block; `mix_columns_serial` followed by InvMixColumns must return the original state.

---
 rtl/mix_columns_serial.sv | 117 +++++++++++
 tb/tb_mix_columns_serial.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_serial.sv
// Forward AES MixColumns with a valid/ready handshake on both sides.
// COLS_PER_CYCLE column-mix units sweep the captured state one column group per clock.
module mix_columns_serial #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] out_data
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_serial: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   // With four columns per cycle the step wraps to zero and col stays at 0.
   localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t       state_q;
   logic [1:0]   col_q;
   logic         in_ready_q;
   logic         out_valid_q;
   logic [0:127] st_q;
   logic [0:127] out_q;
   logic [0:127] out_d;
   logic [1:0]   sel;
   logic         accept;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // c[31:24] is the top byte of the column (a0), c[7:0] the bottom (a3).
   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] r0, r1, r2, r3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      mix_col = {r0, r1, r2, r3};
   endfunction

   assign accept = in_valid && in_ready_q;

   always_comb begin
      out_d = out_q;
      sel   = '0;
      for (int u = 0; u < COLS_PER_CYCLE; u++) begin
         sel = col_q + 2'(u);
         out_d[{sel, 5'b0} +: 32] = mix_col(st_q[{sel, 5'b0} +: 32]);
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         st_q <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         col_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  state_q    <= BUSY;
                  col_q      <= '0;
                  in_ready_q <= 1'b0;
               end
            end
            BUSY: begin
               out_q <= out_d;
               col_q <= col_q + STEP;
               if (col_q == LAST) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_q;

endmodule

// File: tb/tb_mix_columns_serial.sv
// Bench for mix_columns_serial: one instance per legal COLS_PER_CYCLE, checked
// against a GF(2^8) matrix-multiply reference and its inverse.
module tb_mix_columns_serial;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] in_data   [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] out_data  [3];

   int n_tot = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_serial #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g])
      );
   end

   task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   // Plain shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic       hi;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   // Circulant matrix product per column; inv selects InvMixColumns.
   function automatic logic [127:0] mixm(input logic [127:0] s, input bit inv);
      logic [7:0]   base [4];
      logic [127:0] r;
      logic [7:0]   acc;
      if (inv) begin
         base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
      end else begin
         base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
      end
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(base[(j - row + 4) % 4], s[127 - 8 * (4 * c + j) -: 8]);
            r[127 - 8 * (4 * c + row) -: 8] = acc;
         end
      end
      return r;
   endfunction

   task automatic scramble(input int k);
      in_valid[k] = 1'($urandom_range(0, 1));
      in_data[k]  = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   // One full transaction on instance k; out_ready is left as the caller set it
   // during the busy phase, forced low for `hold` cycles in DONE, then raised.
   task automatic run_vec(input int k, input logic [127:0] d, input logic [127:0] exp,
                          input int hold, input string tag, output logic [127:0] got);
      int   n;
      int   lat;
      logic rdy_seen;
      n = 0;
      while (!in_ready[k] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "/ready"}, 136'(in_ready[k]), 136'(1));
      in_valid[k] = 1'b1;
      in_data[k]  = d;
      @(posedge clk); #1;
      rdy_seen = in_ready[k];
      lat = 0;
      while (!out_valid[k] && lat < 10) begin
         scramble(k);
         @(posedge clk); #1;
         lat++;
         if (!out_valid[k]) rdy_seen = rdy_seen | in_ready[k];
      end
      chk({tag, "/latency"}, 136'(lat), 136'(4 >> k));
      chk({tag, "/busy_in_ready"}, 136'(rdy_seen), 136'(0));
      got = out_data[k];
      chk({tag, "/data"}, 136'(got), 136'(exp));
      for (int i = 0; i < hold; i++) begin
         out_ready[k] = 1'b0;
         scramble(k);
         @(posedge clk); #1;
         chk({tag, "/hold"}, {6'b0, out_valid[k], in_ready[k], out_data[k]}, {6'b0, 1'b1, 1'b0, got});
      end
      out_ready[k] = 1'b1;
      in_valid[k]  = 1'b0;
      @(posedge clk); #1;
      chk({tag, "/handoff"}, 136'({out_valid[k], in_ready[k]}), 136'(2'b01));
   endtask

   initial begin : main
      logic [127:0] got;
      logic [127:0] d;
      for (int k = 0; k < 3; k++) begin
         in_valid[k]  = 1'b0;
         in_data[k]   = '0;
         out_ready[k] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
         chk($sformatf("reset%0d", k), {6'b0, in_ready[k], out_valid[k], out_data[k]}, 136'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
         chk($sformatf("post_reset%0d", k), 136'({in_ready[k], out_valid[k]}), 136'(2'b10));

      // Known-answer vector with backpressure while toggling the input side.
      run_vec(0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5,
              128'h046681e5_e0cb199a_48f8d37a_2806264c, 10, "v1", got);

      // Back-to-back with out_ready tied high.
      out_ready[0] = 1'b1;
      run_vec(0, 128'h49db873b_45395389_7f02d2f1_77de961a,
              128'h584dcaf1_1b4b5aac_dbe7caa8_1b6bb0e5, 0, "v2", got);
      run_vec(0, 128'hacc1d6b8_efb55a7b_1323cfdf_457311b5,
              128'h75ec0993_200b6333_53c0cf7c_bb25d0dc, 0, "v3", got);

      for (int k = 0; k < 3; k++)
         run_vec(k, 128'hdb135345_f20a225c_01010101_c6c6c6c6,
                 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1, $sformatf("fixed%0d", k), got);

      // Reset two cycles after accept.
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b1;
      in_data[0]   = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst", {6'b0, out_valid[0], in_ready[0], out_data[0]}, 136'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_release", 136'({in_ready[0], out_valid[0]}), 136'(2'b10));
      run_vec(0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5,
              128'h046681e5_e0cb199a_48f8d37a_2806264c, 2, "v1_again", got);

      // Random states through every width, checked forward and round-trip.
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 1000; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready[k] = 1'($urandom_range(0, 1));
            run_vec(k, d, mixm(d, 1'b0), int'($urandom_range(0, 2)), $sformatf("rnd%0d", k), got);
            chk($sformatf("roundtrip%0d", k), 136'(mixm(got, 1'b1)), 136'(d));
         end
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
